// File: rtl/itlb_pkg.sv
// itlb_pkg - shared types and constants for the instruction TLB.
//
// Contents:
//   itlb_state_e  - miss-handling FSM states (IDLE, REQ, WAIT)
//   PAGE_BITS_DEF - default page offset width
//   VPN_WIDTH     - virtual page number width for the default 32-bit VA
//   itlb_entry_t  - one translation entry {valid, vpn, ppn}
//
// The entry struct is sized from these package constants, so the top-level
// VA_WIDTH / PAGE_BITS / PPN_WIDTH parameters must stay consistent with them.
package itlb_pkg;

    localparam int VA_WIDTH_DEF  = 32;
    localparam int PAGE_BITS_DEF = 12;
    localparam int PPN_WIDTH_DEF = 20;
    localparam int VPN_WIDTH     = VA_WIDTH_DEF - PAGE_BITS_DEF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } itlb_state_e;

    typedef struct packed {
        logic                     valid;
        logic [VPN_WIDTH-1:0]     vpn;
        logic [PPN_WIDTH_DEF-1:0] ppn;
    } itlb_entry_t;

endpackage

// File: rtl/itlb_match.sv
// itlb_match - parallel tag compare for the fully-associative ITLB.
//
// Ports:
//   valid      in  ENTRIES        per-entry valid bits
//   vpns       in  ENTRIES*VPN_W  per-entry VPN tags, entry i at [i*VPN_W +: VPN_W]
//   lookup_vpn in  VPN_W          VPN being looked up
//   hit        out 1              some valid entry matches
//   index      out IDX_W          index of the matching entry (0 when no hit)
//
// The array never holds two valid entries with the same VPN, so the match
// vector is one-hot or zero and OR-ing the indices of set bits encodes it.
module itlb_match #(
    parameter  int ENTRIES = 8,
    parameter  int VPN_W   = 20,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]       valid,
    input  logic [ENTRIES*VPN_W-1:0] vpns,
    input  logic [VPN_W-1:0]         lookup_vpn,
    output logic                     hit,
    output logic [IDX_W-1:0]         index
);

    logic [ENTRIES-1:0] match;

    always_comb begin
        match = '0;
        index = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = valid[i] && (vpns[i*VPN_W +: VPN_W] == lookup_vpn);
            if (match[i]) begin
                index = index | IDX_W'(i);
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/itlb.sv
// itlb - instruction TLB between fetch and the page-table walker.
//
// A fully-associative array of VPN->PPN translations answers fetch lookups
// combinationally. On a miss, fetch is stalled, a single-cycle request is
// sent to the PTW, and the returned PPN is installed round-robin.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   F_va_valid/F_va  fetch lookup request
//   F_flush          invalidate every entry and reset the victim pointer
//   F_hit/F_pa       translation result, valid in the lookup cycle
//   F_stall          fetch must hold F_va
//   Itlb_pa_request  one-cycle request to the PTW, with Itlb_va = {0, VPN}
//   F_ptw_valid      one-cycle PTW response carrying F_ptw_pa
//   hit_cnt/miss_cnt saturating performance counters (only with ITLB_PERF_EN)
//
// Build option: define ITLB_PERF_EN to add the hit/miss counters.
module itlb
    import itlb_pkg::*;
#(
    parameter int VA_WIDTH  = 32,
    parameter int PAGE_BITS = PAGE_BITS_DEF,
    parameter int PPN_WIDTH = 20,
    parameter int ENTRIES   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          F_va_valid,
    input  logic [VA_WIDTH-1:0]           F_va,
    input  logic                          F_flush,
    output logic                          F_hit,
    output logic [PPN_WIDTH+PAGE_BITS-1:0] F_pa,
    output logic                          F_stall,
    output logic                          Itlb_pa_request,
    output logic [VA_WIDTH-1:0]           Itlb_va,
    input  logic                          F_ptw_valid,
    input  logic [PPN_WIDTH-1:0]          F_ptw_pa
`ifdef ITLB_PERF_EN
    ,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt
`endif
);

    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);

    itlb_state_e      state_q, state_d;
    logic [IDX_W-1:0] victim_q, victim_d;
    logic             drop_q, drop_d;
    logic [VPN_W-1:0] req_vpn_q, req_vpn_d;
    itlb_entry_t      entries_q [ENTRIES];
    itlb_entry_t      entries_d [ENTRIES];

    logic [VPN_W-1:0]         lookup_vpn;
    logic [ENTRIES-1:0]       valid_vec;
    logic [ENTRIES*VPN_W-1:0] vpn_flat;
    logic                     match_hit;
    logic [IDX_W-1:0]         match_idx;

    assign lookup_vpn = F_va[VA_WIDTH-1:PAGE_BITS];

    always_comb begin
        valid_vec = '0;
        vpn_flat  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec[i]                  = entries_q[i].valid;
            vpn_flat[i*VPN_W +: VPN_W]    = entries_q[i].vpn;
        end
    end

    itlb_match #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W)
    ) u_match (
        .valid      (valid_vec),
        .vpns       (vpn_flat),
        .lookup_vpn (lookup_vpn),
        .hit        (match_hit),
        .index      (match_idx)
    );

    // Lookups are only answered while idle; during a miss the stall holds
    // fetch regardless of what the array contains.
    always_comb begin
        F_hit           = F_va_valid && (state_q == IDLE) && match_hit;
        F_pa            = F_hit ? {entries_q[match_idx].ppn, F_va[PAGE_BITS-1:0]} : '0;
        F_stall         = (F_va_valid && !F_hit) || (state_q != IDLE);
        Itlb_pa_request = (state_q == REQ);
        Itlb_va         = (state_q == REQ) ? VA_WIDTH'(req_vpn_q) : '0;
    end

    // Miss FSM, refill and flush. Flush is applied last so it overrides a
    // refill landing in the same cycle; a flush during REQ/WAIT sets drop so
    // the response already in flight is discarded rather than installed.
    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        drop_d    = drop_q;
        req_vpn_d = req_vpn_q;
        entries_d = entries_q;

        case (state_q)
            IDLE: begin
                if (F_va_valid && !match_hit) begin
                    req_vpn_d = lookup_vpn;
                    state_d   = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
                if (F_flush) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (F_ptw_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !F_flush) begin
                        entries_d[victim_q] = itlb_entry_t'{valid: 1'b1, vpn: req_vpn_q, ppn: F_ptw_pa};
                        victim_d            = victim_q + 1'b1;
                    end
                end else if (F_flush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (F_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_d[i].valid = 1'b0;
            end
            victim_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            victim_q  <= '0;
            drop_q    <= 1'b0;
            req_vpn_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            victim_q  <= victim_d;
            drop_q    <= drop_d;
            req_vpn_q <= req_vpn_d;
            entries_q <= entries_d;
        end
    end

`ifdef ITLB_PERF_EN
    // Saturating counters: hits per F_hit cycle, misses per IDLE->REQ entry.
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (F_hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if ((state_q == IDLE) && (state_d == REQ) && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_itlb.sv
// tb_itlb - directed self-checking bench for the itlb.
//
// Inputs change 1 time unit after a rising edge and outputs are checked
// 1 time unit later, well clear of the next edge. The PTW is modelled inline:
// it answers a request 8 cycles later with PPN = requested VPN + 4.
module tb_itlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        F_va_valid;
    logic [31:0] F_va;
    logic        F_flush;
    logic        F_hit;
    logic [31:0] F_pa;
    logic        F_stall;
    logic        Itlb_pa_request;
    logic [31:0] Itlb_va;
    logic        F_ptw_valid;
    logic [19:0] F_ptw_pa;
`ifdef ITLB_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int assert_count = 0;
    int fail_count   = 0;
    int req_count    = 0;

    itlb dut (
        .clk             (clk),
        .rst             (rst),
        .F_va_valid      (F_va_valid),
        .F_va            (F_va),
        .F_flush         (F_flush),
        .F_hit           (F_hit),
        .F_pa            (F_pa),
        .F_stall         (F_stall),
        .Itlb_pa_request (Itlb_pa_request),
        .Itlb_va         (Itlb_va),
        .F_ptw_valid     (F_ptw_valid),
        .F_ptw_pa        (F_ptw_pa)
`ifdef ITLB_PERF_EN
        ,
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Counts request cycles so hits can be shown to issue none.
    always @(negedge clk) begin
        if (Itlb_pa_request) req_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic va_valid, input logic [31:0] va,
                                 input logic flush, input logic ptw_valid,
                                 input logic [19:0] ptw_pa);
        F_va_valid  = va_valid;
        F_va        = va;
        F_flush     = flush;
        F_ptw_valid = ptw_valid;
        F_ptw_pa    = ptw_pa;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
            $error("[TB] %s observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Full miss starting in the current cycle: request, 8-cycle PTW latency,
    // refill, then a hit with PPN = VPN + 4 in the cycle after the response.
    task automatic do_miss(input logic [31:0] va);
        logic [19:0] vpn;
        int          req_before;
        vpn        = va[31:12];
        req_before = req_count;
        applyStimulus(1'b1, va, 1'b0, 1'b0, 20'h0);
        checkOutput("miss_stall", 32'(F_stall), 32'd1);
        checkOutput("miss_no_hit", 32'(F_hit), 32'd0);
        tick();
        checkOutput("req_pulse", 32'(Itlb_pa_request), 32'd1);
        checkOutput("req_va", Itlb_va, {12'h000, vpn});
        tick();
        checkOutput("req_one_cycle", 32'(Itlb_pa_request), 32'd0);
        repeat (7) begin
            checkOutput("wait_stall", 32'(F_stall), 32'd1);
            tick();
        end
        applyStimulus(1'b1, va, 1'b0, 1'b1, vpn + 20'd4);
        checkOutput("resp_cycle_stall", 32'(F_stall), 32'd1);
        tick();
        applyStimulus(1'b1, va, 1'b0, 1'b0, 20'h0);
        checkOutput("refill_hit", 32'(F_hit), 32'd1);
        checkOutput("refill_pa", F_pa, {vpn + 20'd4, va[11:0]});
        checkOutput("refill_no_stall", 32'(F_stall), 32'd0);
        checkOutput("refill_req_count", 32'(req_count), 32'(req_before + 1));
    endtask

    initial begin
        int          req_before;
        logic [31:0] va;

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 20'h0);
        checkOutput("rst_hit", 32'(F_hit), 32'd0);
        checkOutput("rst_stall", 32'(F_stall), 32'd0);
        checkOutput("rst_pa", F_pa, 32'h0);
        checkOutput("rst_req", 32'(Itlb_pa_request), 32'd0);
        checkOutput("rst_itlb_va", Itlb_va, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Cold miss on 0x0000_3ABC
        $display("[TB] cold miss");
        do_miss(32'h0000_3ABC);

        // Hit on the same page, no new request
        req_before = req_count;
        applyStimulus(1'b1, 32'h0000_3FF0, 1'b0, 1'b0, 20'h0);
        checkOutput("hit_same_cycle", 32'(F_hit), 32'd1);
        checkOutput("hit_pa", F_pa, 32'h0000_7FF0);
        checkOutput("hit_no_stall", 32'(F_stall), 32'd0);
        tick();
        checkOutput("hit_no_request", 32'(req_count), 32'(req_before));

        // Fill VPNs 0x10..0x18: nine installs into eight entries. VPN 3 sits
        // in entry 0, so 0x10..0x16 fill 1..7, 0x17 wraps to 0, 0x18 evicts 0x10.
        $display("[TB] replacement");
        for (int v = 16; v <= 24; v++) begin
            va = 32'(v) << 12;
            do_miss(va);
        end
        applyStimulus(1'b1, 32'h0001_7123, 1'b0, 1'b0, 20'h0);
        checkOutput("wrap_entry_hit", 32'(F_hit), 32'd1);
        checkOutput("wrap_entry_pa", F_pa, 32'h0001_B123);
        applyStimulus(1'b1, 32'h0001_1004, 1'b0, 1'b0, 20'h0);
        checkOutput("survivor_hit", 32'(F_hit), 32'd1);
        checkOutput("survivor_pa", F_pa, 32'h0001_5004);
        do_miss(32'h0001_0000);

        // Flush while idle, then 0x0001_1000 must miss again
        $display("[TB] flush idle");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 20'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 20'h0);
        do_miss(32'h0001_1000);

        // Flush during WAIT: response dropped, re-request after IDLE
        $display("[TB] flush in wait");
        req_before = req_count;
        applyStimulus(1'b1, 32'h0002_2000, 1'b0, 1'b0, 20'h0);
        checkOutput("fw_stall", 32'(F_stall), 32'd1);
        tick();
        checkOutput("fw_req", 32'(Itlb_pa_request), 32'd1);
        tick();
        applyStimulus(1'b1, 32'h0002_2000, 1'b1, 1'b0, 20'h0);
        tick();
        applyStimulus(1'b1, 32'h0002_2000, 1'b0, 1'b0, 20'h0);
        repeat (6) tick();
        applyStimulus(1'b1, 32'h0002_2000, 1'b0, 1'b1, 20'h00026);
        tick();
        applyStimulus(1'b1, 32'h0002_2000, 1'b0, 1'b0, 20'h0);
        checkOutput("fw_dropped_no_hit", 32'(F_hit), 32'd0);
        checkOutput("fw_dropped_stall", 32'(F_stall), 32'd1);
        checkOutput("fw_one_request", 32'(req_count), 32'(req_before + 1));
        do_miss(32'h0002_2000);

        // Flush coincident with the response: flush wins
        $display("[TB] flush with response");
        applyStimulus(1'b1, 32'h0001_1000, 1'b0, 1'b0, 20'h0);
        checkOutput("fc_stall", 32'(F_stall), 32'd1);
        tick();
        tick();
        repeat (7) tick();
        applyStimulus(1'b1, 32'h0001_1000, 1'b1, 1'b1, 20'h00015);
        tick();
        applyStimulus(1'b1, 32'h0001_1000, 1'b0, 1'b0, 20'h0);
        checkOutput("fc_no_hit", 32'(F_hit), 32'd0);
        checkOutput("fc_stall_again", 32'(F_stall), 32'd1);
        do_miss(32'h0001_1000);

        // Reset while in WAIT; late response ignored, array empty
        $display("[TB] reset in wait");
        applyStimulus(1'b1, 32'h0003_3000, 1'b0, 1'b0, 20'h0);
        tick();
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0003_3000, 1'b0, 1'b0, 20'h0);
        checkOutput("rw_req", 32'(Itlb_pa_request), 32'd0);
        checkOutput("rw_stall", 32'(F_stall), 32'd0);
        tick();
        rst = 1'b0;
        req_before = req_count;
        applyStimulus(1'b0, 32'h0003_3000, 1'b0, 1'b1, 20'h00037);
        tick();
        applyStimulus(1'b0, 32'h0003_3000, 1'b0, 1'b0, 20'h0);
        checkOutput("rw_late_no_stall", 32'(F_stall), 32'd0);
        checkOutput("rw_late_no_req", 32'(req_count), 32'(req_before));
        applyStimulus(1'b1, 32'h0003_3000, 1'b0, 1'b0, 20'h0);
        checkOutput("rw_empty_miss", 32'(F_hit), 32'd0);
        checkOutput("rw_empty_stall", 32'(F_stall), 32'd1);
        applyStimulus(1'b1, 32'h0001_1000, 1'b0, 1'b0, 20'h0);
        checkOutput("rw_old_entry_gone", 32'(F_hit), 32'd0);
        checkOutput("rw_old_entry_pa", F_pa, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 20'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
